// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe
// ARM-style data-processing control decode with a single D->E pipeline
// register and the NZCV flag register updated when the E op retires.
//
// Optional feature macro: ALU_CTRL_CARRY_FWD_EN
//   defined   : the C flag is forwarded from the retiring E op into the
//               D-stage carry-in decode, so no carry hazard stall is needed.
//   undefined : a carry-consuming op (ADC/SBC/RSC) in D waits one cycle
//               behind a flag-writing op in E (hazard_stall_o).
//
// Pipeline handshake (the single rule every checker can bind to):
//   - An op in D is accepted into E on a clock edge where stall_i=0,
//     valid_d=1, flush_i=0 and hazard_stall_o=0; otherwise, if stall_i=0,
//     a bubble is loaded instead.
//   - The E op retires on a clock edge where valid_e=1 and stall_i=0; only
//     then are its flag effects committed.
//   - stall_i=1 freezes the E register and the flags completely.
//   - hazard_stall_o asks the upstream stage to hold the D op unchanged.

module alu_ctrl_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  // decode stage
  input  logic             valid_d,
  input  logic             alu_op_d,
  input  logic [3:0]       opcode_d,
  input  logic             set_flags_d,
  input  logic             bx_d,
  input  logic             reg_to_cpsr_d,
  // pipeline control
  input  logic             stall_i,
  input  logic             flush_i,
  // execute-stage ALU results
  input  logic [WIDTH-1:0] alu_result_e,
  input  logic             alu_cout_e,
  input  logic             alu_vout_e,
  // execute-stage controls
  output logic             valid_e,
  output logic [2:0]       alu_operation_e,
  output logic             invert_b_e,
  output logic             reverse_inputs_e,
  output logic             alu_carry_e,
  output logic             no_reg_write_e,
  output logic [3:0]       flags_o,
  output logic             hazard_stall_o
);

  // ARM data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU operation select encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_EOR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;
  localparam logic [2:0] ALU_BX  = 3'b101;

  // Arithmetic ops update C and V; logical and move ops leave them alone.
  function automatic logic is_arith(input logic [3:0] op);
    is_arith = (op[3:1] == 3'b001) || (op[3:1] == 3'b010) ||
               (op[3:1] == 3'b011) || (op[3:1] == 3'b101);
  endfunction

  // Ops whose carry-in depends on the current C flag.
  function automatic logic uses_carry(input logic [3:0] op);
    uses_carry = (op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC);
  endfunction

  // Internal E-stage state that is not exported directly
  logic       set_flags_e;
  logic       reg_to_cpsr_e;
  logic       arith_e;
  logic [3:0] flags_q;

  // D-stage decode results
  logic [2:0] op_sel_d;
  logic       invert_b_d;
  logic       reverse_d;
  logic       carry_in_d;
  logic       no_wr_d;
  logic       arith_d;
  logic       carry_src;
  logic       retire_e;
  logic       load_op;

  assign retire_e = valid_e & ~stall_i;
  assign arith_d  = alu_op_d & is_arith(opcode_d);
  assign flags_o  = flags_q;

`ifdef ALU_CTRL_CARRY_FWD_EN
  // C seen by the D-stage decode: the value the retiring E op is about to write
  always_comb begin
    carry_src = flags_q[1];
    if (retire_e && reg_to_cpsr_e)
      carry_src = alu_result_e[WIDTH-3];
    else if (retire_e && set_flags_e && arith_e)
      carry_src = alu_cout_e;
  end

  assign hazard_stall_o = 1'b0;
`else
  // C seen by the D-stage decode: the committed flag only
  always_comb begin
    carry_src = flags_q[1];
  end

  // A carry consumer must wait until a flag-writing op in E has retired
  assign hazard_stall_o = valid_d & alu_op_d & uses_carry(opcode_d) &
                          valid_e & (set_flags_e | reg_to_cpsr_e) & ~flush_i;
`endif

  // Op is accepted into E only if it is real, not squashed and not waiting on C
  assign load_op = valid_d & ~flush_i & ~hazard_stall_o;

  // Combinational decode of the D-stage fields into ALU controls
  always_comb begin
    op_sel_d   = ALU_ADD;
    invert_b_d = 1'b0;
    reverse_d  = 1'b0;
    carry_in_d = 1'b0;
    no_wr_d    = reg_to_cpsr_d;
    if (alu_op_d) begin
      case (opcode_d)
        OP_AND, OP_TST: op_sel_d = ALU_AND;
        OP_EOR, OP_TEQ: op_sel_d = ALU_EOR;
        OP_SUB, OP_CMP: begin
          invert_b_d = 1'b1;
          carry_in_d = 1'b1;
        end
        OP_RSB: begin
          invert_b_d = 1'b1;
          reverse_d  = 1'b1;
          carry_in_d = 1'b1;
        end
        OP_ADD, OP_CMN: op_sel_d = ALU_ADD;
        OP_ADC: carry_in_d = carry_src;
        OP_SBC: begin
          invert_b_d = 1'b1;
          carry_in_d = carry_src;
        end
        OP_RSC: begin
          invert_b_d = 1'b1;
          reverse_d  = 1'b1;
          carry_in_d = carry_src;
        end
        OP_ORR: op_sel_d = ALU_ORR;
        OP_MOV: op_sel_d = ALU_MOV;
        OP_BIC: begin
          op_sel_d   = ALU_AND;
          invert_b_d = 1'b1;
        end
        OP_MVN: begin
          op_sel_d   = ALU_MOV;
          invert_b_d = 1'b1;
        end
        default: op_sel_d = ALU_ADD;
      endcase
      // Compare/test ops (10xx) only produce flags
      if (opcode_d[3:2] == 2'b10)
        no_wr_d = 1'b1;
    end else if (bx_d) begin
      op_sel_d = ALU_BX;
    end
  end

  // E register: hold on stall, otherwise load the D op or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e          <= 1'b0;
      alu_operation_e  <= ALU_ADD;
      invert_b_e       <= 1'b0;
      reverse_inputs_e <= 1'b0;
      alu_carry_e      <= 1'b0;
      no_reg_write_e   <= 1'b0;
      set_flags_e      <= 1'b0;
      reg_to_cpsr_e    <= 1'b0;
      arith_e          <= 1'b0;
    end else if (!stall_i) begin
      if (load_op) begin
        valid_e          <= 1'b1;
        alu_operation_e  <= op_sel_d;
        invert_b_e       <= invert_b_d;
        reverse_inputs_e <= reverse_d;
        alu_carry_e      <= carry_in_d;
        no_reg_write_e   <= no_wr_d;
        set_flags_e      <= set_flags_d;
        reg_to_cpsr_e    <= reg_to_cpsr_d;
        arith_e          <= arith_d;
      end else begin
        valid_e          <= 1'b0;
        alu_operation_e  <= ALU_ADD;
        invert_b_e       <= 1'b0;
        reverse_inputs_e <= 1'b0;
        alu_carry_e      <= 1'b0;
        no_reg_write_e   <= 1'b0;
        set_flags_e      <= 1'b0;
        reg_to_cpsr_e    <= 1'b0;
        arith_e          <= 1'b0;
      end
    end
  end

  // NZCV register: committed only when the E op retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else if (retire_e) begin
      if (reg_to_cpsr_e) begin
        // Direct flag write wins over any result-derived update
        flags_q <= alu_result_e[WIDTH-1:WIDTH-4];
      end else if (set_flags_e) begin
        flags_q[3] <= alu_result_e[WIDTH-1];
        flags_q[2] <= (alu_result_e == '0);
        if (arith_e) begin
          flags_q[1] <= alu_cout_e;
          flags_q[0] <= alu_vout_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed testbench for alu_ctrl_pipe (WIDTH=32, FLAG_RESET=4'b1001).
// Builds with or without ALU_CTRL_CARRY_FWD_EN; the carry-hazard step
// selects its expectations from the same macro.

module tb_alu_ctrl_pipe;

  localparam int         W      = 32;
  localparam logic [3:0] FRESET = 4'b1001;

  logic         clk;
  logic         reset;
  logic         valid_d;
  logic         alu_op_d;
  logic [3:0]   opcode_d;
  logic         set_flags_d;
  logic         bx_d;
  logic         reg_to_cpsr_d;
  logic         stall_i;
  logic         flush_i;
  logic [W-1:0] alu_result_e;
  logic         alu_cout_e;
  logic         alu_vout_e;
  logic         valid_e;
  logic [2:0]   alu_operation_e;
  logic         invert_b_e;
  logic         reverse_inputs_e;
  logic         alu_carry_e;
  logic         no_reg_write_e;
  logic [3:0]   flags_o;
  logic         hazard_stall_o;

  int checks = 0;
  int errors = 0;

  alu_ctrl_pipe #(.WIDTH(W), .FLAG_RESET(FRESET)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_d          (valid_d),
    .alu_op_d         (alu_op_d),
    .opcode_d         (opcode_d),
    .set_flags_d      (set_flags_d),
    .bx_d             (bx_d),
    .reg_to_cpsr_d    (reg_to_cpsr_d),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .alu_result_e     (alu_result_e),
    .alu_cout_e       (alu_cout_e),
    .alu_vout_e       (alu_vout_e),
    .valid_e          (valid_e),
    .alu_operation_e  (alu_operation_e),
    .invert_b_e       (invert_b_e),
    .reverse_inputs_e (reverse_inputs_e),
    .alu_carry_e      (alu_carry_e),
    .no_reg_write_e   (no_reg_write_e),
    .flags_o          (flags_o),
    .hazard_stall_o   (hazard_stall_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic a, input logic [3:0] opc, input logic s,
                          input logic bx, input logic r2c);
    valid_d       = 1'b1;
    alu_op_d      = a;
    opcode_d      = opc;
    set_flags_d   = s;
    bx_d          = bx;
    reg_to_cpsr_d = r2c;
  endtask

  task automatic drive_idle();
    valid_d       = 1'b0;
    alu_op_d      = 1'b0;
    opcode_d      = 4'b0000;
    set_flags_d   = 1'b0;
    bx_d          = 1'b0;
    reg_to_cpsr_d = 1'b0;
  endtask

  task automatic drive_alu(input logic [W-1:0] res, input logic co, input logic vo);
    alu_result_e = res;
    alu_cout_e   = co;
    alu_vout_e   = vo;
  endtask

  // comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {alu_op, bx, opcode, exp_op[2:0], inv, rev, cin, nrw}; flags C=1 while these run
  logic [12:0] dec_tbl [16] = '{
    {1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0},  // AND
    {1'b1, 1'b0, 4'b0001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0},  // EOR
    {1'b1, 1'b0, 4'b0100, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0},  // ADD
    {1'b1, 1'b0, 4'b0101, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0},  // ADC
    {1'b1, 1'b0, 4'b0110, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0},  // SBC
    {1'b1, 1'b0, 4'b0111, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0},  // RSC
    {1'b1, 1'b0, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1},  // TST
    {1'b1, 1'b0, 4'b1001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1},  // TEQ
    {1'b1, 1'b0, 4'b1010, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1},  // CMP
    {1'b1, 1'b0, 4'b1011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1},  // CMN
    {1'b1, 1'b0, 4'b1100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0},  // ORR
    {1'b1, 1'b0, 4'b1101, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0},  // MOV
    {1'b1, 1'b0, 4'b1110, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0},  // BIC
    {1'b1, 1'b0, 4'b1111, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0},  // MVN
    {1'b0, 1'b1, 4'b0101, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0},  // BX
    {1'b0, 1'b0, 4'b0010, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0}   // non-ALU op
  };

  initial begin
    logic [12:0] v;

    // reset held while clock runs and D presents a valid op
    reset   = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive_op(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    drive_alu(32'h8000_0000, 1'b1, 1'b1);
    repeat (3) tick();
    chk("rst_valid_e", valid_e, 0);
    chk("rst_op", alu_operation_e, 3'b010);
    chk("rst_inv", invert_b_e, 0);
    chk("rst_rev", reverse_inputs_e, 0);
    chk("rst_cin", alu_carry_e, 0);
    chk("rst_nrw", no_reg_write_e, 0);
    chk("rst_flags", flags_o, FRESET);
    chk("rst_hazard", hazard_stall_o, 0);
    drive_idle();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", valid_e, 0);

    // SUBS with zero result, carry out
    drive_op(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    chk("subs_valid", valid_e, 1);
    chk("subs_op", alu_operation_e, 3'b010);
    chk("subs_inv", invert_b_e, 1);
    chk("subs_cin", alu_carry_e, 1);
    chk("subs_nrw", no_reg_write_e, 0);
    drive_idle();
    drive_alu(32'h0, 1'b1, 1'b0);
    tick();
    chk("subs_flags", flags_o, 4'b0110);
    chk("subs_bubble", valid_e, 0);

    // RSB without S: reversed, no flag change on retire
    drive_op(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rsb_rev", reverse_inputs_e, 1);
    chk("rsb_inv", invert_b_e, 1);
    chk("rsb_cin", alu_carry_e, 1);
    drive_idle();
    drive_alu(32'h1234_5678, 1'b0, 1'b1);
    tick();
    chk("rsb_flags", flags_o, 4'b0110);

    // decode table, back-to-back with no flag writers
    drive_alu(32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = dec_tbl[i];
      drive_op(v[12], v[10:7], 1'b0, v[11], 1'b0);
      tick();
      chk($sformatf("dec%0d_valid", i), valid_e, 1);
      chk($sformatf("dec%0d_op", i), alu_operation_e, v[6:4]);
      chk($sformatf("dec%0d_inv", i), invert_b_e, v[3]);
      chk($sformatf("dec%0d_rev", i), reverse_inputs_e, v[2]);
      chk($sformatf("dec%0d_cin", i), alu_carry_e, v[1]);
      chk($sformatf("dec%0d_nrw", i), no_reg_write_e, v[0]);
    end
    drive_idle();
    tick();
    chk("dec_flags", flags_o, 4'b0110);

    // ANDS held by stall for three cycles, ORR waiting in D
    drive_op(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    drive_alu(32'h8000_0000, 1'b0, 1'b1);
    tick();
    drive_op(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), valid_e, 1);
      chk($sformatf("stall%0d_op", i), alu_operation_e, 3'b000);
      chk($sformatf("stall%0d_flags", i), flags_o, 4'b0110);
    end
    stall_i = 1'b0;
    tick();
    chk("ands_flags", flags_o, 4'b1010);
    chk("orr_after_stall", alu_operation_e, 3'b011);
    drive_idle();
    tick();

    // MSR-style flag write, with S also set: direct load wins
    drive_op(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    chk("msr_nrw", no_reg_write_e, 1);
    chk("msr_op", alu_operation_e, 3'b010);
    drive_idle();
    drive_alu(32'h5000_0000, 1'b1, 1'b1);
    tick();
    chk("msr_flags", flags_o, 4'b0101);

    // ADDS then ADC back-to-back; C is 0 before ADDS retires
    drive_op(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    drive_op(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    drive_alu(32'h0000_0001, 1'b1, 1'b0);
    #1;
`ifdef ALU_CTRL_CARRY_FWD_EN
    chk("fwd_no_hazard", hazard_stall_o, 0);
    tick();
    chk("fwd_adc_valid", valid_e, 1);
    chk("fwd_adc_cin", alu_carry_e, 1);
    chk("fwd_flags", flags_o, 4'b0010);
`else
    chk("hz_stall", hazard_stall_o, 1);
    tick();
    chk("hz_bubble", valid_e, 0);
    chk("hz_flags", flags_o, 4'b0010);
    chk("hz_release", hazard_stall_o, 0);
    tick();
    chk("hz_adc_valid", valid_e, 1);
    chk("hz_adc_cin", alu_carry_e, 1);
`endif
    drive_idle();
    tick();

    // flush with CMP in D while TEQS retires
    drive_op(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0);
    tick();
    drive_op(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    drive_alu(32'hF000_0000, 1'b0, 1'b1);
    tick();
    chk("flush_valid", valid_e, 0);
    chk("teq_flags", flags_o, 4'b1010);
    flush_i = 1'b0;
    drive_idle();

    // reset asserted mid-cycle with ADDS in E
    drive_op(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    drive_idle();
    drive_alu(32'h0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", valid_e, 0);
    chk("async_rst_flags", flags_o, FRESET);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_release_flags", flags_o, FRESET);
    chk("rst_release_valid", valid_e, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
